dot_acc: RTL and testbench



---
 rtl/dot_acc_pkg.sv | 17 +
 rtl/dot_acc_mult.sv | 74 +++++++
 rtl/dot_acc.sv | 155 +++++++++++++++
 tb/tb_dot_acc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Shared definitions for the dot_acc multiply-accumulate sequencer.
// Contents:
//   MULT_CYC : number of cycles the sequential multiplier stays busy after a start.
//   state_e  : sequencer states.
package dot_acc_pkg;

  localparam int unsigned MULT_CYC = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/dot_acc_mult.sv
// Sequential 8x8 shift-add multiplier used by dot_acc.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous, active-high reset
//   start_i : one-cycle strobe that captures a_i/b_i and begins a multiply
//   a_i/b_i : 8-bit operands, sampled with start_i
//   busy_o  : high for MULT_CYC cycles after the start strobe
//   p_o     : 16-bit product, valid once busy_o falls
module dot_acc_mult
  import dot_acc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic [15:0] p_o
);

  localparam int unsigned CntW = $clog2(MULT_CYC);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     mcand_q, mcand_d;
  logic [7:0]      mplier_q, mplier_d;
  logic [15:0]     prod_q, prod_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {8'b0, a_i};
      mplier_d = b_i;
      prod_d   = '0;
    end else if (busy_q) begin
      // One multiplier bit per cycle, LSB first; the multiplicand shifts up to match.
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (cnt_q == CntW'(MULT_CYC - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign busy_o = busy_q;
  assign p_o    = prod_q;

endmodule

// File: rtl/dot_acc.sv
// Dot-product sequencer in front of the sequential 8x8 multiplier.
// Takes a length command, then streams operand pairs over valid/ready, multiplies each pair
// and accumulates the products. The final sum is presented on y_bo with a one-cycle done pulse.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous, active-low reset
//   start_i : command strobe, only honoured when idle
//   len_bi  : number of operand pairs, captured with start_i
//   a_bi    : operand A
//   b_bi    : operand B
//   valid_i : operand pair valid
//   ready_o : a pair is accepted this cycle when valid_i is also high
//   busy_o  : high whenever a command is in progress (including the done cycle)
//   done_o  : one-cycle pulse, y_bo is final
//   y_bo    : dot-product result, held until the next command completes
//   ovf_o   : sticky accumulator carry-out for the current command
module dot_acc
  import dot_acc_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_bi,
  input  logic [7:0]       a_bi,
  input  logic [7:0]       b_bi,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] y_bo,
  output logic             ovf_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;

  logic             mult_start;
  logic             mult_busy;
  logic [15:0]      mult_p;
  logic [ACC_W:0]   sum_ext;

  dot_acc_mult u_mult (
    .clk_i   (clk_i),
    .rst_i   (~rst_i),
    .start_i (mult_start),
    .a_i     (a_q),
    .b_i     (b_q),
    .busy_o  (mult_busy),
    .p_o     (mult_p)
  );

  // Extra top bit captures the carry-out that drives the sticky overflow flag.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(mult_p);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    a_d        = a_q;
    b_d        = b_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    mult_start = 1'b0;
    busy_o     = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (len_bi != '0) begin
            len_d   = len_bi;
            state_d = StFetch;
          end else begin
            y_d     = '0;
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        ready_o = 1'b1;
        if (valid_i) begin
          a_d     = a_bi;
          b_d     = b_bi;
          state_d = StIssue;
        end
      end
      StIssue: begin
        mult_start = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        // The multiplier raises busy the cycle after the start, so the first low cycle
        // here is the one where the product is complete.
        if (!mult_busy) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            y_d     = acc_d;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign y_bo  = y_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc. Two instances (ACC_W=20 and ACC_W=16) see identical
// stimulus; a cycle-stepped driver keeps an arithmetic model of the expected outputs and a
// negedge process compares every output of both instances on every cycle after reset.
module tb_dot_acc;
  import dot_acc_pkg::*;

  localparam int ELEM_CYC = MULT_CYC + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  a, b;
  logic        valid;

  logic        r20, bz20, d20, o20;
  logic [19:0] y20;
  logic        r16, bz16, d16, o16;
  logic [15:0] y16;

  dot_acc #(.LEN_W(4), .ACC_W(20)) dut20 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .len_bi(len), .a_bi(a), .b_bi(b),
    .valid_i(valid), .ready_o(r20), .busy_o(bz20), .done_o(d20), .y_bo(y20), .ovf_o(o20)
  );

  dot_acc #(.LEN_W(4), .ACC_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .len_bi(len), .a_bi(a), .b_bi(b),
    .valid_i(valid), .ready_o(r16), .busy_o(bz16), .done_o(d16), .y_bo(y16), .ovf_o(o16)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model state
  bit exp_ready = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  bit exp_ovf20 = 1'b0, exp_ovf16 = 1'b0;
  int exp_y20 = 0, exp_y16 = 0;
  int sum = 0, k = 0, cmd_len = 0;
  int start_cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready20", 32'(r20), 32'(exp_ready));
      chk("busy20", 32'(bz20), 32'(exp_busy));
      chk("done20", 32'(d20), 32'(exp_done));
      chk("y20", 32'(y20), 32'(exp_y20));
      chk("ovf20", 32'(o20), 32'(exp_ovf20));
      chk("ready16", 32'(r16), 32'(exp_ready));
      chk("busy16", 32'(bz16), 32'(exp_busy));
      chk("done16", 32'(d16), 32'(exp_done));
      chk("y16", 32'(y16), 32'(exp_y16));
      chk("ovf16", 32'(o16), 32'(exp_ovf16));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      step();
    end
  endtask

  task automatic start_cmd(input int l);
    start = 1'b1;
    len = 4'(l);
    valid = 1'($urandom);
    start_cyc = cyc;
    step();
    start = 1'b0;
    len = 4'($urandom);
    cmd_len = l;
    k = 0;
    sum = 0;
    exp_busy = 1'b1;
    exp_ovf20 = 1'b0;
    exp_ovf16 = 1'b0;
    if (l == 0) begin
      exp_done = 1'b1;
      exp_y20 = 0;
      exp_y16 = 0;
      done_cyc = cyc;
      step();
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end
  endtask

  // Offers one pair after 'gap' idle fetch cycles. abort_at>0 pulls reset low in that
  // cycle after acceptance and returns once the reset has taken effect.
  task automatic do_pair(input int gap, input logic [7:0] pa, input logic [7:0] pb,
                         input bit pulse, input int abort_at);
    for (int i = 0; i < gap; i++) begin
      valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      exp_ready = 1'b1;
      step();
    end
    valid = 1'b1;
    a = pa;
    b = pb;
    exp_ready = 1'b1;
    step();
    exp_ready = 1'b0;
    for (int i = 0; i < ELEM_CYC - 1; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_y20 = 0;
        exp_y16 = 0;
        exp_ovf20 = 1'b0;
        exp_ovf16 = 1'b0;
        sum = 0;
        return;
      end
      valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      start = pulse && (i == 3);
      len = 4'($urandom_range(1, 15));
      step();
    end
    start = 1'b0;
    sum += int'(pa) * int'(pb);
    k++;
    exp_ovf20 = (sum >= (1 << 20));
    exp_ovf16 = (sum >= (1 << 16));
    if (k == cmd_len) begin
      exp_done = 1'b1;
      exp_y20 = sum % (1 << 20);
      exp_y16 = sum % (1 << 16);
      done_cyc = cyc;
      step();
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    a = '0;
    b = '0;
    valid = 1'b0;
    step();
    chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Basic three-element product
    start_cmd(3);
    do_pair(0, 8'd1, 8'd2, 1'b0, 0);
    do_pair(0, 8'd3, 8'd4, 1'b0, 0);
    do_pair(0, 8'd5, 8'd6, 1'b0, 0);
    chk("t1_latency", 32'(done_cyc - start_cyc), 32'd34);
    chk("t1_y", 32'(y20), 32'd44);
    chk("t1_ovf", 32'(o20), 32'd0);
    idle(2);

    // Zero-length command
    start_cmd(0);
    chk("t2_latency", 32'(done_cyc - start_cyc), 32'd1);
    chk("t2_y", 32'(y20), 32'd0);
    idle(2);

    // Maximum length, maximum operands
    start_cmd(15);
    for (int i = 0; i < 15; i++) do_pair(0, 8'd255, 8'd255, 1'b0, 0);
    chk("t3_y20", 32'(y20), 32'd975375);
    chk("t3_ovf20", 32'(o20), 32'd0);
    chk("t3_y16", 32'(y16), 32'd57871);
    chk("t3_ovf16", 32'(o16), 32'd1);
    idle(1);

    // Wrap in the 16-bit accumulator
    start_cmd(2);
    do_pair(0, 8'd255, 8'd255, 1'b0, 0);
    do_pair(0, 8'd255, 8'd255, 1'b0, 0);
    chk("t4_y16", 32'(y16), 32'd64514);
    chk("t4_ovf16", 32'(o16), 32'd1);
    chk("t4_y20", 32'(y20), 32'd130050);
    chk("t4_ovf20", 32'(o20), 32'd0);
    idle(2);

    // Withheld valid and ignored start pulses
    start_cmd(2);
    do_pair(5, 8'($urandom), 8'($urandom), 1'b1, 0);
    do_pair(5, 8'($urandom), 8'($urandom), 1'b1, 0);
    chk("t5_latency", 32'(done_cyc - start_cyc), 32'd33);
    chk("t5_y", 32'(y20), 32'(exp_y20));
    idle(2);

    // Reset during the wait of element 2, then a fresh command
    start_cmd(3);
    do_pair(0, 8'($urandom), 8'($urandom), 1'b0, 0);
    do_pair(0, 8'($urandom), 8'($urandom), 1'b0, 4);
    chk("t6_rst_y", 32'(y20), 32'd0);
    chk("t6_rst_busy", 32'(bz20), 32'd0);
    chk("t6_rst_ovf", 32'(o16), 32'd0);
    idle(2);
    start_cmd(1);
    do_pair(0, 8'd7, 8'd9, 1'b0, 0);
    chk("t6_y", 32'(y20), 32'd63);
    chk("t6_latency", 32'(done_cyc - start_cyc), 32'd12);
    idle(1);

    // Randomized commands
    for (int n = 0; n < 25; n++) begin
      int l;
      l = $urandom_range(0, 15);
      start_cmd(l);
      for (int e = 0; e < l; e++) begin
        do_pair($urandom_range(0, 3), 8'($urandom), 8'($urandom), 1'($urandom), 0);
      end
      idle($urandom_range(0, 3));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
